accel_issue_cu: RTL and testbench
=================================

# accel_issue_cu

Core-side issue/collect control unit for the dummy iterative accelerator: the requester end of the accelerator's valid/ready operand and result handshakes. Accepts one operation from the core issue logic, presents it to the accelerator until accepted, collects the result, and forwards it tagged to the core result bus (CDB). Provides a watchdog timeout and flush propagation. Exactly one operation is outstanding at a time.

## Interface
- DataWidth, 64, operand/result width
- TagWidth, 4, core tag width
- CtlWidth, 8, accelerator control field width (latency/imm)
- TimeoutCycles, 64, max cycles waiting for a result; 0 disables the watchdog
---
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  core pipeline flush
- issue_valid_i / issue_ready_o  in/out  1  upstream handshake
- issue_tag_i  in  TagWidth  operation tag
- issue_ctl_i  in  CtlWidth  accelerator control
- issue_data_i  in  DataWidth  operand
- acc_valid_o / acc_ready_i  out/in  1  request handshake to accelerator
- acc_ctl_o  out  CtlWidth  registered control
- acc_data_o  out  DataWidth  registered operand
- acc_valid_i / acc_ready_o  in/out  1  result handshake from accelerator
- acc_data_i  in  DataWidth  accelerator result
- acc_flush_o  out  1  flush to accelerator
- cdb_valid_o / cdb_ready_i  out/in  1  result handshake to CDB
- cdb_tag_o  out  TagWidth  result tag
- cdb_data_o  out  DataWidth  result data
- cdb_except_o  out  1  result is a timeout exception
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT_RES, RES.
- IDLE: issue_ready_o = !flush_i. On issue_valid_i: capture tag/ctl/data into request regs → REQ.
- REQ: acc_valid_o = 1; acc_ctl_o/acc_data_o driven from regs, stable until accepted; acc_ready_o = 1.
  - acc_ready_i && acc_valid_i (combinational accelerator, ctl = 0): capture acc_data_i, except = 0 → RES.
  - acc_ready_i only → WAIT_RES; timeout counter cleared.
  - else stay in REQ (the watchdog does not run in REQ).
- WAIT_RES: acc_ready_o = 1; counter increments each cycle.
  - acc_valid_i: capture data, except = 0 → RES (a result takes priority over a timeout in the same cycle).
  - Counter == TimeoutCycles-1 without acc_valid_i (TimeoutCycles > 0): acc_flush_o = 1 for that cycle; result data = 0, except = 1 → RES.
- RES: cdb_valid_o = 1; tag/data/except held stable. On cdb_ready_i → IDLE.
- issue_ready_o = 0 outside IDLE; no RES→issue bypass.
- acc_ready_o = 0 in IDLE and RES.
- acc_flush_o = flush_i | timeout pulse.
- Flush: flush_i in any state → IDLE next cycle. A result arriving or a CDB handshake in the flush cycle is discarded. An issue_valid_i in the flush cycle is not accepted.
- Reset: state IDLE, counter 0, all data/tag/except regs 0.

## Timing
- Outputs while rst_i is high and the first cycle after: acc_valid_o, acc_ready_o, cdb_valid_o, cdb_except_o, acc_flush_o (unless flush_i), busy_o = 0. Data/tag outputs = 0. issue_ready_o = 0 while rst_i is high, 1 in IDLE afterwards.
- Issue accepted at cycle t → acc_valid_o at t+1.
- Combinational accelerator, accepted at t+1 → cdb_valid_o at t+2.
- Iterative accelerator asserting acc_valid_i k cycles after acceptance → cdb_valid_o one cycle later.
- Minimum throughput: one operation per 3 cycles.
- Timeout: request accepted at cycle a → acc_flush_o pulse at a+TimeoutCycles, cdb_valid_o with except at a+TimeoutCycles+1.
- Counter width: $clog2(TimeoutCycles+1); no wrap, because the counter is cleared on leaving WAIT_RES.
- All outputs are driven from registered state. acc_flush_o and issue_ready_o are also combinational from flush_i.

## Structure
- Package accel_issue_pkg: state enum (logic [1:0]) and a result struct {tag, data, except}.
- Sub-module accel_timeout_counter: clr/en/tc counter parameterised by terminal count, with tc tied off when TimeoutCycles == 0.

## Test plan
- Combinational op: issue tag 3, ctl 0, data 0x5 at cycle 0; accelerator acc_ready_i = acc_valid_i = 1 with data 0xA at cycle 1 → cdb_valid_o at cycle 2 with tag 3, data 0xA, except 0.
- Iterative op with backpressure: acc_ready_i held low for 2 cycles → acc_data_o stable throughout. Result after 4 cycles with cdb_ready_i low for 3 cycles → cdb outputs stable, IDLE after the handshake.
- Timeout: TimeoutCycles = 8, accelerator never returns → acc_flush_o is a 1-cycle pulse 8 cycles after acceptance; cdb_except_o = 1, data 0.
- Flush in WAIT_RES while acc_valid_i = 1 → no cdb_valid_o; acc_flush_o = 1 in that cycle; IDLE next cycle with issue_ready_o = 1.
- Reset asserted in RES with cdb_ready_i low → next cycle IDLE, cdb_valid_o = 0; issue_valid_i during reset is not captured.

Source files
------------

// File: rtl/accel_issue_pkg.sv
// Shared types for the accelerator issue/collect control unit.
package accel_issue_pkg;

    // Result storage widths; the top-level DataWidth/TagWidth default to these.
    localparam int TAG_W  = 4;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_RES      = 2'd3
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              except;
    } result_t;

endpackage

// File: rtl/accel_timeout_counter.sv
// Watchdog up-counter: clear/enable, terminal-count flag at TermCount-1.
// TermCount == 0 disables the watchdog (tc never asserts).
module accel_timeout_counter #(
    parameter int TermCount = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    if (TermCount == 0) begin : g_disabled
        assign tc_o = 1'b0;
    end else begin : g_enabled
        localparam int CntWidth = $clog2(TermCount + 1);

        logic [CntWidth-1:0] r_count;

        // Count waiting cycles; the owner clears it whenever it is not waiting.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_count <= '0;
            end else if (clr_i) begin
                r_count <= '0;
            end else if (en_i) begin
                r_count <= r_count + 1'b1;
            end
        end

        assign tc_o = en_i && (r_count == CntWidth'(TermCount - 1));
    end

endmodule

// File: rtl/accel_issue_cu.sv
// Core-side issue/collect control unit for the iterative accelerator.
// One operation outstanding: issue -> request -> wait -> result to CDB.
//
// state       | meaning
// ST_IDLE     | ready for a new operation from the core
// ST_REQ      | presenting operand/ctl to the accelerator
// ST_WAIT_RES | request accepted, waiting for result (watchdog running)
// ST_RES      | presenting tagged result on the CDB
module accel_issue_cu
    import accel_issue_pkg::*;
#(
    parameter int DataWidth     = DATA_W,
    parameter int TagWidth      = TAG_W,
    parameter int CtlWidth      = 8,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [TagWidth-1:0]  issue_tag_i,
    input  logic [CtlWidth-1:0]  issue_ctl_i,
    input  logic [DataWidth-1:0] issue_data_i,
    output logic                 acc_valid_o,
    input  logic                 acc_ready_i,
    output logic [CtlWidth-1:0]  acc_ctl_o,
    output logic [DataWidth-1:0] acc_data_o,
    input  logic                 acc_valid_i,
    output logic                 acc_ready_o,
    input  logic [DataWidth-1:0] acc_data_i,
    output logic                 acc_flush_o,
    output logic                 cdb_valid_o,
    input  logic                 cdb_ready_i,
    output logic [TagWidth-1:0]  cdb_tag_o,
    output logic [DataWidth-1:0] cdb_data_o,
    output logic                 cdb_except_o,
    output logic                 busy_o
);

    state_e                r_state;
    state_e                w_next;
    logic [TagWidth-1:0]   r_req_tag;
    logic [CtlWidth-1:0]   r_req_ctl;
    logic [DataWidth-1:0]  r_req_data;
    result_t               r_res;
    logic                  w_cap_req;
    logic                  w_cap_res;
    logic                  w_timeout;
    logic                  w_tc;

    accel_timeout_counter #(
        .TermCount(TimeoutCycles)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (r_state != ST_WAIT_RES),
        .en_i  (r_state == ST_WAIT_RES),
        .tc_o  (w_tc)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and capture strobes; flush overrides everything.
    always_comb begin
        w_next    = r_state;
        w_cap_req = 1'b0;
        w_cap_res = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (issue_valid_i) begin
                    w_cap_req = 1'b1;
                    w_next    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (acc_ready_i && acc_valid_i) begin
                    w_cap_res = 1'b1;
                    w_next    = ST_RES;
                end else if (acc_ready_i) begin
                    w_next = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (acc_valid_i) begin
                    w_cap_res = 1'b1;
                    w_next    = ST_RES;
                end else if (w_tc) begin
                    w_timeout = 1'b1;
                    w_cap_res = 1'b1;
                    w_next    = ST_RES;
                end
            end
            ST_RES: begin
                if (cdb_ready_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (flush_i) begin
            w_next    = ST_IDLE;
            w_cap_req = 1'b0;
            w_cap_res = 1'b0;
        end
    end

    // Request registers hold the operation stable until the accelerator takes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_tag  <= '0;
            r_req_ctl  <= '0;
            r_req_data <= '0;
        end else if (w_cap_req) begin
            r_req_tag  <= issue_tag_i;
            r_req_ctl  <= issue_ctl_i;
            r_req_data <= issue_data_i;
        end
    end

    // Result register; a timeout returns zero data with the exception flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res <= '0;
        end else if (w_cap_res) begin
            r_res.tag    <= TAG_W'(r_req_tag);
            r_res.data   <= w_timeout ? '0 : DATA_W'(acc_data_i);
            r_res.except <= w_timeout;
        end
    end

    assign issue_ready_o = (r_state == ST_IDLE) && !flush_i && !rst_i;
    assign acc_valid_o   = (r_state == ST_REQ);
    assign acc_ready_o   = (r_state == ST_REQ) || (r_state == ST_WAIT_RES);
    assign acc_ctl_o     = r_req_ctl;
    assign acc_data_o    = r_req_data;
    assign acc_flush_o   = flush_i | w_timeout;
    assign cdb_valid_o   = (r_state == ST_RES);
    assign cdb_tag_o     = TagWidth'(r_res.tag);
    assign cdb_data_o    = DataWidth'(r_res.data);
    assign cdb_except_o  = r_res.except;
    assign busy_o        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_accel_issue_cu.sv
// Directed self-checking bench for accel_issue_cu (TimeoutCycles = 8).
`timescale 1ns/1ps
module tb_accel_issue_cu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [3:0]  issue_tag_i;
    logic [7:0]  issue_ctl_i;
    logic [63:0] issue_data_i;
    logic        acc_valid_o;
    logic        acc_ready_i;
    logic [7:0]  acc_ctl_o;
    logic [63:0] acc_data_o;
    logic        acc_valid_i;
    logic        acc_ready_o;
    logic [63:0] acc_data_i;
    logic        acc_flush_o;
    logic        cdb_valid_o;
    logic        cdb_ready_i;
    logic [3:0]  cdb_tag_o;
    logic [63:0] cdb_data_o;
    logic        cdb_except_o;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;

    accel_issue_cu #(
        .DataWidth(64), .TagWidth(4), .CtlWidth(8), .TimeoutCycles(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_tag_i(issue_tag_i), .issue_ctl_i(issue_ctl_i), .issue_data_i(issue_data_i),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
        .acc_ctl_o(acc_ctl_o), .acc_data_o(acc_data_o),
        .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o), .acc_data_i(acc_data_i),
        .acc_flush_o(acc_flush_o),
        .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i),
        .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o), .cdb_except_o(cdb_except_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        issue_tag_i   = '0;
        issue_ctl_i   = '0;
        issue_data_i  = '0;
        acc_ready_i   = 1'b0;
        acc_valid_i   = 1'b0;
        acc_data_i    = '0;
        cdb_ready_i   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i         = 1'b1;
        issue_valid_i = 1'b1;
        issue_tag_i   = 4'hF;
        issue_data_i  = 64'hDEAD;
        tick();
        tick();
        vectors++;
        if ({issue_ready_o, busy_o, acc_valid_o, acc_ready_o, cdb_valid_o, cdb_except_o, acc_flush_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0000000",
                {issue_ready_o, busy_o, acc_valid_o, acc_ready_o, cdb_valid_o, cdb_except_o, acc_flush_o});
        end
        vectors++;
        if ({cdb_tag_o, cdb_data_o, acc_data_o, acc_ctl_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: tag %h data %h acc_data %h ctl %h want all 0",
                cdb_tag_o, cdb_data_o, acc_data_o, acc_ctl_o);
        end
        issue_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();
        vectors++;
        if ({issue_ready_o, busy_o, acc_valid_o, cdb_valid_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL post_reset: ready/busy/accv/cdbv %b want 1000",
                {issue_ready_o, busy_o, acc_valid_o, cdb_valid_o});
        end
    endtask

    task automatic test_comb_op();
        issue_valid_i = 1'b1;
        issue_tag_i   = 4'd3;
        issue_ctl_i   = 8'd0;
        issue_data_i  = 64'h5;
        tick();
        issue_valid_i = 1'b0;
        vectors++;
        if ({acc_valid_o, acc_ready_o, issue_ready_o, busy_o} !== 4'b1101 || acc_data_o !== 64'h5 || acc_ctl_o !== 8'd0) begin
            miscompares++;
            $display("FAIL comb_req: v/r/ir/busy %b data %h ctl %h want 1101 5 00",
                {acc_valid_o, acc_ready_o, issue_ready_o, busy_o}, acc_data_o, acc_ctl_o);
        end
        acc_ready_i = 1'b1;
        acc_valid_i = 1'b1;
        acc_data_i  = 64'hA;
        tick();
        acc_ready_i = 1'b0;
        acc_valid_i = 1'b0;
        acc_data_i  = 64'h77;
        vectors++;
        if (cdb_valid_o !== 1'b1 || cdb_tag_o !== 4'd3 || cdb_data_o !== 64'hA || cdb_except_o !== 1'b0 || acc_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL comb_res: v %b tag %h data %h exc %b accr %b want 1 3 a 0 0",
                cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_except_o, acc_ready_o);
        end
        cdb_ready_i = 1'b1;
        tick();
        cdb_ready_i = 1'b0;
        vectors++;
        if ({busy_o, cdb_valid_o, issue_ready_o} !== 3'b001) begin
            miscompares++;
            $display("FAIL comb_idle: busy/cdbv/ir %b want 001", {busy_o, cdb_valid_o, issue_ready_o});
        end
    endtask

    task automatic test_backpressure();
        int bad;
        issue_valid_i = 1'b1;
        issue_tag_i   = 4'd5;
        issue_ctl_i   = 8'd4;
        issue_data_i  = 64'h1234;
        tick();
        issue_valid_i = 1'b0;
        issue_data_i  = 64'hFFFF;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (acc_valid_o !== 1'b1 || acc_data_o !== 64'h1234 || acc_ctl_o !== 8'd4) bad++;
            if (i < 2) tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_req_stable: %0d unstable cycles, data %h want 1234", bad, acc_data_o);
        end
        acc_ready_i = 1'b1;
        tick();
        acc_ready_i = 1'b0;
        vectors++;
        if ({acc_valid_o, acc_ready_o, busy_o, cdb_valid_o} !== 4'b0110) begin
            miscompares++;
            $display("FAIL bp_wait: accv/accr/busy/cdbv %b want 0110",
                {acc_valid_o, acc_ready_o, busy_o, cdb_valid_o});
        end
        tick();
        tick();
        tick();
        acc_valid_i = 1'b1;
        acc_data_i  = 64'hBEEF;
        #1;
        vectors++;
        if (acc_flush_o !== 1'b0 || cdb_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_timeout: flush %b cdbv %b want 0 0", acc_flush_o, cdb_valid_o);
        end
        tick();
        acc_valid_i = 1'b0;
        acc_data_i  = 64'h0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (cdb_valid_o !== 1'b1 || cdb_tag_o !== 4'd5 || cdb_data_o !== 64'hBEEF || cdb_except_o !== 1'b0) bad++;
            if (i < 3) tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_res_stable: %0d bad cycles, tag %h data %h want 5 beef", bad, cdb_tag_o, cdb_data_o);
        end
        cdb_ready_i = 1'b1;
        tick();
        cdb_ready_i = 1'b0;
        vectors++;
        if ({busy_o, cdb_valid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_idle: busy/cdbv %b want 00", {busy_o, cdb_valid_o});
        end
    endtask

    task automatic test_timeout();
        int pulses;
        int first;
        issue_valid_i = 1'b1;
        issue_tag_i   = 4'd9;
        issue_data_i  = 64'h42;
        tick();
        issue_valid_i = 1'b0;
        acc_ready_i   = 1'b1;
        tick();
        acc_ready_i = 1'b0;
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= 8; i++) begin
            if (acc_flush_o === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i < 8) tick();
        end
        vectors++;
        if (pulses != 1 || first != 8) begin
            miscompares++;
            $display("FAIL timeout_pulse: %0d pulses first at +%0d want 1 at +8", pulses, first);
        end
        tick();
        vectors++;
        if (cdb_valid_o !== 1'b1 || cdb_except_o !== 1'b1 || cdb_data_o !== 64'h0 || cdb_tag_o !== 4'd9 || acc_flush_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_res: v %b exc %b data %h tag %h flush %b want 1 1 0 9 0",
                cdb_valid_o, cdb_except_o, cdb_data_o, cdb_tag_o, acc_flush_o);
        end
        cdb_ready_i = 1'b1;
        tick();
        cdb_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        issue_valid_i = 1'b1;
        issue_tag_i   = 4'd7;
        tick();
        issue_valid_i = 1'b0;
        acc_ready_i   = 1'b1;
        tick();
        acc_ready_i = 1'b0;
        acc_valid_i = 1'b1;
        acc_data_i  = 64'h99;
        flush_i     = 1'b1;
        #1;
        vectors++;
        if (acc_flush_o !== 1'b1 || issue_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_pulse: flush %b ir %b want 1 0", acc_flush_o, issue_ready_o);
        end
        tick();
        flush_i     = 1'b0;
        acc_valid_i = 1'b0;
        #1;
        vectors++;
        if ({cdb_valid_o, busy_o, issue_ready_o, acc_flush_o} !== 4'b0010) begin
            miscompares++;
            $display("FAIL flush_idle: cdbv/busy/ir/flush %b want 0010",
                {cdb_valid_o, busy_o, issue_ready_o, acc_flush_o});
        end
        issue_valid_i = 1'b1;
        flush_i       = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        flush_i       = 1'b0;
        vectors++;
        if ({busy_o, acc_valid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_no_issue: busy/accv %b want 00", {busy_o, acc_valid_o});
        end
    endtask

    task automatic test_reset_in_res();
        issue_valid_i = 1'b1;
        issue_tag_i   = 4'd2;
        tick();
        issue_valid_i = 1'b0;
        acc_ready_i   = 1'b1;
        acc_valid_i   = 1'b1;
        acc_data_i    = 64'h55;
        tick();
        acc_ready_i = 1'b0;
        acc_valid_i = 1'b0;
        rst_i         = 1'b1;
        issue_valid_i = 1'b1;
        vectors++;
        if (cdb_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_res_setup: cdbv %b want 1", cdb_valid_o);
        end
        tick();
        vectors++;
        if ({cdb_valid_o, busy_o, issue_ready_o} !== 3'b000 || cdb_data_o !== 64'h0 || cdb_tag_o !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_res: cdbv/busy/ir %b data %h tag %h want 000 0 0",
                {cdb_valid_o, busy_o, issue_ready_o}, cdb_data_o, cdb_tag_o);
        end
        rst_i         = 1'b0;
        issue_valid_i = 1'b0;
        tick();
        vectors++;
        if ({busy_o, acc_valid_o, issue_ready_o} !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_no_capture: busy/accv/ir %b want 001", {busy_o, acc_valid_o, issue_ready_o});
        end
    endtask

    task automatic test_back_to_back();
        int got;
        got = 0;
        cdb_ready_i = 1'b1;
        for (int op = 0; op < 2; op++) begin
            issue_valid_i = 1'b1;
            issue_tag_i   = 4'(op + 10);
            issue_data_i  = 64'(op);
            tick();
            issue_valid_i = 1'b0;
            acc_ready_i   = 1'b1;
            acc_valid_i   = 1'b1;
            acc_data_i    = 64'(100 + op);
            tick();
            acc_ready_i = 1'b0;
            acc_valid_i = 1'b0;
            if (cdb_valid_o === 1'b1 && cdb_tag_o === 4'(op + 10) && cdb_data_o === 64'(100 + op)) got++;
            tick();
            if (issue_ready_o !== 1'b1) got = -10;
        end
        cdb_ready_i = 1'b0;
        vectors++;
        if (got != 2) begin
            miscompares++;
            $display("FAIL back_to_back: %0d good results want 2", got);
        end
    endtask

    initial begin
        test_reset();
        test_comb_op();
        test_backpressure();
        test_timeout();
        test_flush();
        test_reset_in_res();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
